// File: rtl/jtag_types_pkg.sv
// Shared command/state types and preamble TMS tables for the JTAG host master.
// Preamble tables are sent LSB first; every table starts from Run-Test/Idle.
package jtag_types_pkg;

  localparam int CMD_LEN_W = 6;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IR_SCAN = 2'd1,
    OP_DR_SCAN = 2'd2
  } jtag_op_t;

  typedef enum logic [2:0] {
    ST_AUTO_RST = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PRE      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_POST     = 3'd4,
    ST_DONE     = 3'd5
  } jtag_master_state_t;

  localparam logic [5:0] RST_TMS    = 6'b011111;
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam logic [2:0] DR_PRE_TMS = 3'b001;

  // The reserved encoding behaves exactly like a TAP reset.
  function automatic jtag_op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_IR_SCAN;
      2'd2:    return OP_DR_SCAN;
      default: return OP_RESET;
    endcase
  endfunction

  function automatic logic [5:0] pre_tms(input jtag_op_t op);
    case (op)
      OP_IR_SCAN: return {2'b00, IR_PRE_TMS};
      OP_DR_SCAN: return {3'b000, DR_PRE_TMS};
      default:    return RST_TMS;
    endcase
  endfunction

  function automatic logic [2:0] pre_last(input jtag_op_t op);
    case (op)
      OP_IR_SCAN: return 3'd3;
      OP_DR_SCAN: return 3'd2;
      default:    return 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: low for CLK_DIV clk then high for CLK_DIV clk while enabled.
// tck_rise/tck_fall mark the clk edge on which TCK changes; disabled holds TCK low.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tck_q, tck_d;
  logic             term;

  always_comb begin
    term      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    tck_rise  = en && term && !tck_q;
    tck_fall  = en && term && tck_q;
    div_cnt_d = '0;
    tck_d     = 1'b0;
    if (en) begin
      div_cnt_d = term ? '0 : div_cnt_q + DIV_W'(1);
      tck_d     = term ? ~tck_q : tck_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      div_cnt_q <= '0;
      tck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tck_q     <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: walks the TAP through RESET / IR-scan / DR-scan from RTI back to RTI.
// One command in flight; cmd_ready low from accept until the rsp_valid cycle.
module jtag_master
  import jtag_types_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CMD_LEN_W-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]   cmd_data,
  output logic                 rsp_valid,
  output logic [MAX_LEN-1:0]   rsp_data,
  output logic                 busy,
  output logic                 TCK,
  output logic                 TMS,
  output logic                 TDI,
  input  logic                 TDO
);

  localparam int IDX_W = $clog2(MAX_LEN);

  jtag_master_state_t   state_q, state_d;
  jtag_op_t             op_q, op_d;
  logic [CMD_LEN_W-1:0] len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [2:0]           slot_q, slot_d;
  logic [IDX_W-1:0]     bit_q, bit_d;
  logic [MAX_LEN-1:0]   rsp_sh_q, rsp_sh_d;
  logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;

  logic                 tck_en, tck_rise, tck_fall;
  jtag_op_t             op_in;
  logic [CMD_LEN_W-1:0] len_in;
  logic [5:0]           new_pre, cur_pre;
  logic                 last_bit;

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk      (clk),
    .nRST     (nRST),
    .en       (tck_en),
    .tck      (TCK),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign tck_en = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);

  always_comb begin
    op_in    = decode_op(cmd_op);
    len_in   = (cmd_len > CMD_LEN_W'(MAX_LEN)) ? CMD_LEN_W'(MAX_LEN) : cmd_len;
    new_pre  = pre_tms(op_in);
    cur_pre  = pre_tms(op_q);
    last_bit = (CMD_LEN_W'(bit_q) == len_q - CMD_LEN_W'(1));

    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    slot_d      = slot_q;
    bit_d       = bit_q;
    rsp_sh_d    = rsp_sh_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;

    case (state_q)
      // Leaving reset behaves like an accepted RESET command.
      ST_AUTO_RST: begin
        op_d     = OP_RESET;
        len_d    = '0;
        data_d   = '0;
        rsp_sh_d = '0;
        slot_d   = '0;
        bit_d    = '0;
        tms_d    = RST_TMS[0];
        tdi_d    = 1'b0;
        state_d  = ST_PRE;
      end
      ST_IDLE: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          op_d        = op_in;
          len_d       = len_in;
          data_d      = cmd_data;
          rsp_sh_d    = '0;
          slot_d      = '0;
          bit_d       = '0;
          if (op_in != OP_RESET && len_in == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PRE;
            tms_d   = new_pre[0];
          end
        end
      end
      ST_PRE: begin
        if (tck_fall) begin
          if (slot_q == pre_last(op_q)) begin
            if (op_q == OP_RESET) begin
              state_d = ST_DONE;
              tms_d   = 1'b0;
            end else begin
              state_d = ST_SHIFT;
              bit_d   = '0;
              tdi_d   = data_q[0];
              tms_d   = (len_q == CMD_LEN_W'(1));
            end
          end else begin
            slot_d = slot_q + 3'd1;
            tms_d  = cur_pre[slot_q + 3'd1];
          end
        end
      end
      ST_SHIFT: begin
        if (tck_rise) begin
          rsp_sh_d[bit_q] = TDO;
        end
        if (tck_fall) begin
          if (last_bit) begin
            state_d = ST_POST;
            slot_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d = bit_q + IDX_W'(1);
            tdi_d = data_q[bit_q + IDX_W'(1)];
            tms_d = (CMD_LEN_W'(bit_q) + CMD_LEN_W'(2) == len_q);
          end
        end
      end
      // Postamble: Update (TMS=1), then back to RTI (TMS=0).
      ST_POST: begin
        if (tck_fall) begin
          tms_d = 1'b0;
          if (slot_q == 3'd1) begin
            state_d = ST_DONE;
          end else begin
            slot_d = 3'd1;
          end
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rsp_sh_q;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_AUTO_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_AUTO_RST;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      slot_q      <= '0;
      bit_q       <= '0;
      rsp_sh_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      slot_q      <= slot_d;
      bit_q       <= bit_d;
      rsp_sh_q    <= rsp_sh_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural TAP walker follows TMS on TCK edges and
// supplies random TDO; each command is checked against sequences built from the TAP rules.
module tb_jtag_master;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, rsp_valid, busy, TCK, TMS, TDI;
  logic [31:0] rsp_data;
  logic        TDO = 1'b0;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // IEEE 1149.1 TAP controller, kept as a plain transition table.
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  function automatic int tap_next(input int s, input logic tms);
    case (s)
      TLR:               return tms ? TLR   : RTI;
      RTI, UPDR, UPIR:   return tms ? SELDR : RTI;
      SELDR:             return tms ? SELIR : CAPDR;
      CAPDR, SHDR:       return tms ? EX1DR : SHDR;
      EX1DR:             return tms ? UPDR  : PADR;
      PADR:              return tms ? EX2DR : PADR;
      EX2DR:             return tms ? UPDR  : SHDR;
      SELIR:             return tms ? TLR   : CAPIR;
      CAPIR, SHIR:       return tms ? EX1IR : SHIR;
      EX1IR:             return tms ? UPIR  : PAIR;
      PAIR:              return tms ? EX2IR : PAIR;
      EX2IR:             return tms ? UPIR  : SHIR;
      default:           return TLR;
    endcase
  endfunction

  int          tap_st = TLR;
  int          cyc = 0, last_rise = 0, tck_n = 0, sh_n = 0, per_err = 0;
  int          rsp_cnt = 0, done_cnt = 0;
  logic [63:0] tms_log = '0;
  logic [31:0] tdi_log = '0, tdo_log = '0;

  always @(posedge clk) begin
    cyc++;
    if (rsp_valid) rsp_cnt++;
  end

  always @(posedge TCK) begin
    if (tck_n > 0 && cyc - last_rise != 2 * CLK_DIV) per_err++;
    last_rise = cyc;
    if (tck_n < 64) tms_log |= 64'(TMS) << tck_n;
    if (tap_st == SHDR || tap_st == SHIR) begin
      if (sh_n < 32) begin
        tdi_log |= 32'(TDI) << sh_n;
        tdo_log |= 32'(TDO) << sh_n;
      end
      sh_n++;
    end
    tck_n++;
    tap_st = tap_next(tap_st, TMS);
  end

  always @(negedge TCK) begin
    if (cyc - last_rise != CLK_DIV) per_err++;
    TDO = 1'($urandom);
  end

  task automatic clear_mon();
    tck_n = 0; sh_n = 0; per_err = 0;
    tms_log = '0; tdi_log = '0; tdo_log = '0;
  endtask

  // Expected TMS stream for one command; returns the number of TCK pulses.
  function automatic int build_tms(input int op, input int len, output logic [63:0] v);
    int n;
    v = '0;
    case (op)
      1:       begin v = 64'b0011;   n = 4; end
      2:       begin v = 64'b001;    n = 3; end
      default: begin v = 64'b011111; n = 6; end
    endcase
    if (op == 1 || op == 2) begin
      if (len == 0) begin
        v = '0;
        return 0;
      end
      v |= 64'd1 << (n + len - 1);
      v |= 64'd1 << (n + len);
      n = n + len + 2;
    end
    return n;
  endfunction

  task automatic check_done(input int op, input int eff, input logic [31:0] data, input int k);
    int          n_exp;
    logic [63:0] tms_exp;
    logic [31:0] mask;
    bit          scan;
    scan  = (op == 1 || op == 2);
    n_exp = build_tms(op, eff, tms_exp);
    mask  = (eff >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << eff) - 64'd1);
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
    chk("rsp_latency", 64'(k), 64'(n_exp * 2 * CLK_DIV + 2));
    chk("tck_count", 64'(tck_n), 64'(n_exp));
    chk("tms_seq", tms_log, tms_exp);
    chk("tck_period", 64'(per_err), 64'd0);
    chk("tap_parked_rti", 64'(tap_st), 64'(RTI));
    chk("done_ready_busy", 64'({cmd_ready, busy}), 64'b10);
    if (scan) begin
      chk("shift_len", 64'(sh_n), 64'(eff));
      chk("tdi_bits", 64'(tdi_log), 64'(data & mask));
      chk("rsp_data", 64'(rsp_data), 64'(tdo_log));
    end else begin
      chk("rsp_data_zero", 64'(rsp_data), 64'd0);
    end
    done_cnt++;
  endtask

  // Caller releases nRST on a negedge just before calling.
  task automatic wait_auto_rst();
    int k;
    @(negedge clk);
    k = 1;
    while (!rsp_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_done(0, 0, 32'd0, k);
  endtask

  task automatic run_cmd(input int op, input int len, input logic [31:0] data,
                         input bit hold, input int abort_at);
    int          k, eff;
    logic [31:0] prev;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    k = 0;
    while (!cmd_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 64'(k < 400), 64'd1);
    prev = rsp_data;
    clear_mon();
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_len   = 6'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_op   = 2'($urandom);
    cmd_len  = 6'($urandom);
    cmd_data = $urandom;
    if (!hold) cmd_valid = 1'b0;
    chk("accept_ready_busy", 64'({cmd_ready, busy}), 64'b01);
    chk("rsp_pulse_ended", 64'(rsp_valid), 64'd0);
    chk("rsp_data_held", 64'(rsp_data), 64'(prev));
    chk("rsp_count", 64'(rsp_cnt), 64'(done_cnt));
    k = 1;
    while (!rsp_valid && k < 400) begin
      if (abort_at >= 0 && sh_n >= abort_at) begin
        nRST = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("arst_tck", 64'(TCK), 64'd0);
        chk("arst_tms_tdi", 64'({TMS, TDI}), 64'b10);
        chk("arst_ready_busy", 64'({cmd_ready, busy}), 64'b01);
        chk("arst_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
        repeat (2) @(negedge clk);
        clear_mon();
        nRST = 1'b1;
        wait_auto_rst();
        return;
      end
      @(negedge clk);
      k++;
    end
    check_done(op, eff, data, k);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: stalled after %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  int op_r, len_r;
  bit hold_r;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tck", 64'(TCK), 64'd0);
    chk("reset_tms_tdi", 64'({TMS, TDI}), 64'b10);
    chk("reset_ready_busy", 64'({cmd_ready, busy}), 64'b01);
    chk("reset_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
    clear_mon();
    nRST = 1'b1;
    wait_auto_rst();

    run_cmd(1, 4, 32'hF, 1'b0, -1);
    run_cmd(2, 8, 32'hA5, 1'b0, -1);
    run_cmd(1, 32, $urandom, 1'b0, -1);
    run_cmd(2, 32, $urandom, 1'b0, -1);
    run_cmd(2, 0, $urandom, 1'b0, -1);
    run_cmd(1, 0, $urandom, 1'b0, -1);
    run_cmd(2, 1, $urandom, 1'b0, -1);
    run_cmd(2, 45, $urandom, 1'b0, -1);
    run_cmd(1, 33, $urandom, 1'b0, -1);
    run_cmd(3, 9, $urandom, 1'b0, -1);
    run_cmd(0, 5, $urandom, 1'b0, -1);

    run_cmd(2, 20, $urandom, 1'b0, 10);
    run_cmd(2, 12, $urandom, 1'b0, -1);

    run_cmd(1, 6, $urandom, 1'b1, -1);
    run_cmd(2, 0, $urandom, 1'b1, -1);
    run_cmd(2, 7, $urandom, 1'b1, -1);
    run_cmd(0, 0, $urandom, 1'b0, -1);

    for (int i = 0; i < 14; i++) begin
      op_r   = $urandom_range(0, 3);
      len_r  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
      hold_r = (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cmd(op_r, len_r, $urandom, hold_r, -1);
    end

    repeat (2) @(negedge clk);
    chk("final_rsp_idle", 64'(rsp_valid), 64'd0);
    chk("final_rsp_count", 64'(rsp_cnt), 64'(done_cnt));
    chk("idle_tck_tms", 64'({TCK, TMS}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
